// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the Lab2 UART transmit path.
//   tx_state_e    : transmit sequencer state encoding
//   BAUD_*        : baud rate codes understood by the baud controller
//   IDLE_LEVEL    : level of the serial line when no frame is in flight
// Optional feature macro seen by users of this package: UART_TX_PARITY_EN
// (adds an even parity bit between the data bits and the stop bits).
// ----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   localparam logic [2:0] BAUD_300    = 3'b000;
   localparam logic [2:0] BAUD_1200   = 3'b001;
   localparam logic [2:0] BAUD_2400   = 3'b010;
   localparam logic [2:0] BAUD_4800   = 3'b011;
   localparam logic [2:0] BAUD_9600   = 3'b100;
   localparam logic [2:0] BAUD_19200  = 3'b101;
   localparam logic [2:0] BAUD_57600  = 3'b110;
   localparam logic [2:0] BAUD_115200 = 3'b111;

   localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_shifter.sv
// ----------------------------------------------------------------------------
// uart_tx_shifter
// Data path of the UART transmitter: shift register, data bit counter and
// parity accumulator, stepped by load/shift strobes from the sequencer.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   load           : capture load_data, clear counter and parity
//   shift          : move to the next data bit, count it, fold it into parity
//   load_data      : word to transmit
//   cur_bit        : data bit currently at the head of the register
//   next_bit       : data bit that becomes current after the next shift
//   parity_bit     : even parity of the whole word (UART_TX_PARITY_EN only)
//   last_bit       : the head bit is the final data bit of the frame
// Macro: UART_TX_PARITY_EN adds the parity accumulator and parity_bit port.
// ----------------------------------------------------------------------------
module uart_tx_shifter
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic                 shift,
   input  logic [DATA_BITS-1:0] load_data,
   output logic                 cur_bit,
   output logic                 next_bit,
`ifdef UART_TX_PARITY_EN
   output logic                 parity_bit,
`endif
   output logic                 last_bit
);

   localparam int CNT_W = $clog2(DATA_BITS);

   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   // Next-state of the shift register and bit counter. Vacated MSBs fill
   // with the idle level so nothing stale can ever reach the line.
   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      if (load) begin
         shift_d = load_data;
         cnt_d   = '0;
      end else if (shift) begin
         shift_d = {IDLE_LEVEL, shift_q[DATA_BITS-1:1]};
         cnt_d   = cnt_q + 1'b1;
      end
   end

   // Register stage for the data path.
   always_ff @(posedge clk) begin
      if (reset) begin
         shift_q <= {DATA_BITS{IDLE_LEVEL}};
         cnt_q   <= '0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

   assign cur_bit  = shift_q[0];
   assign next_bit = shift_q[1];
   assign last_bit = (cnt_q == CNT_W'(DATA_BITS - 1));

`ifdef UART_TX_PARITY_EN
   logic parity_q, parity_d;

   // Parity accumulates each bit as it leaves the head of the register.
   always_comb begin
      parity_d = parity_q;
      if (load) begin
         parity_d = 1'b0;
      end else if (shift) begin
         parity_d = parity_q ^ shift_q[0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= parity_d;
      end
   end

   // The sequencer needs the parity while the final data bit is still at the
   // head, so the head bit is folded in here rather than waiting a cycle.
   assign parity_bit = parity_q ^ shift_q[0];
`endif

endmodule

// File: rtl/uart_tx_controller.sv
// ----------------------------------------------------------------------------
// uart_tx_controller
// UART transmit sequencer. Owns the baud tick generator (code, enable and
// phase-align clear) and shifts one frame onto txd per accepted write:
// start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stops.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   tx_en             : transmitter enable, gates acceptance of new writes
//   cfg_baud_select   : requested baud code, tracked only while idle
//   tx_wr, tx_data    : single-cycle write strobe and the word to send
//   baud_tick         : one-cycle bit-rate pulse from the baud controller
//   baud_select       : baud code driven to the baud controller
//   baud_enable       : baud controller enable, high for the whole frame
//   baud_clr          : one-cycle phase-align pulse after acceptance
//   txd               : serial line, idle high
//   tx_busy, tx_done  : frame in progress / end-of-frame pulse
//   tx_overrun        : pulse one cycle after a dropped write
// Macro: UART_TX_PARITY_EN inserts an even parity bit after the data bits.
// ----------------------------------------------------------------------------
module uart_tx_controller
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tx_en,
   input  logic [2:0]           cfg_baud_select,
   input  logic                 tx_wr,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 baud_tick,
   output logic [2:0]           baud_select,
   output logic                 baud_enable,
   output logic                 baud_clr,
   output logic                 txd,
   output logic                 tx_busy,
   output logic                 tx_done,
   output logic                 tx_overrun
);

   tx_state_e  state_q, state_d;
   logic       txd_q, txd_d;
   logic       tx_busy_q, tx_busy_d;
   logic       tx_done_q, tx_done_d;
   logic       tx_overrun_q, tx_overrun_d;
   logic       baud_enable_q, baud_enable_d;
   logic       baud_clr_q, baud_clr_d;
   logic [2:0] baud_select_q, baud_select_d;
   logic       stop_cnt_q, stop_cnt_d;

   logic sh_load, sh_shift;
   logic cur_bit, next_bit, last_bit;
`ifdef UART_TX_PARITY_EN
   logic parity_bit;
`endif

   logic tick_ok;
   logic accept;

   uart_tx_shifter #(
      .DATA_BITS (DATA_BITS)
   ) u_shifter (
      .clk        (clk),
      .reset      (reset),
      .load       (sh_load),
      .shift      (sh_shift),
      .load_data  (tx_data),
      .cur_bit    (cur_bit),
      .next_bit   (next_bit),
`ifdef UART_TX_PARITY_EN
      .parity_bit (parity_bit),
`endif
      .last_bit   (last_bit)
   );

   // A tick coinciding with the phase-align clear belongs to the old baud
   // phase and must not advance the frame. A write is taken only when idle,
   // enabled, and not in the tx_done cycle, so frames never abut.
   assign tick_ok = baud_tick && !baud_clr_q;
   assign accept  = tx_wr && tx_en && (state_q == ST_IDLE) && !tx_done_q;

   // Next-state and next-output logic for the frame sequencer. Pulsed
   // outputs default low; everything else holds unless a tick moves it.
   always_comb begin
      state_d       = state_q;
      txd_d         = txd_q;
      tx_busy_d     = tx_busy_q;
      tx_done_d     = 1'b0;
      tx_overrun_d  = tx_wr && !accept;
      baud_enable_d = baud_enable_q;
      baud_clr_d    = 1'b0;
      baud_select_d = baud_select_q;
      stop_cnt_d    = stop_cnt_q;
      sh_load       = 1'b0;
      sh_shift      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            baud_select_d = cfg_baud_select;
            if (accept) begin
               sh_load       = 1'b1;
               state_d       = ST_START;
               txd_d         = 1'b0;
               tx_busy_d     = 1'b1;
               baud_enable_d = 1'b1;
               baud_clr_d    = 1'b1;
            end
         end
         ST_START: begin
            if (tick_ok) begin
               state_d = ST_DATA;
               txd_d   = cur_bit;
            end
         end
         ST_DATA: begin
            if (tick_ok) begin
               sh_shift = 1'b1;
               if (last_bit) begin
`ifdef UART_TX_PARITY_EN
                  state_d = ST_PARITY;
                  txd_d   = parity_bit;
`else
                  state_d    = ST_STOP;
                  txd_d      = IDLE_LEVEL;
                  stop_cnt_d = 1'b0;
`endif
               end else begin
                  txd_d = next_bit;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (tick_ok) begin
               state_d    = ST_STOP;
               txd_d      = IDLE_LEVEL;
               stop_cnt_d = 1'b0;
            end
         end
`endif
         ST_STOP: begin
            if (tick_ok) begin
               if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                  state_d       = ST_IDLE;
                  tx_busy_d     = 1'b0;
                  baud_enable_d = 1'b0;
                  tx_done_d     = 1'b1;
               end else begin
                  stop_cnt_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            txd_d   = IDLE_LEVEL;
         end
      endcase
   end

   // Single register stage for the sequencer so every output is a flop.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         txd_q         <= IDLE_LEVEL;
         tx_busy_q     <= 1'b0;
         tx_done_q     <= 1'b0;
         tx_overrun_q  <= 1'b0;
         baud_enable_q <= 1'b0;
         baud_clr_q    <= 1'b0;
         baud_select_q <= BAUD_300;
         stop_cnt_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         txd_q         <= txd_d;
         tx_busy_q     <= tx_busy_d;
         tx_done_q     <= tx_done_d;
         tx_overrun_q  <= tx_overrun_d;
         baud_enable_q <= baud_enable_d;
         baud_clr_q    <= baud_clr_d;
         baud_select_q <= baud_select_d;
         stop_cnt_q    <= stop_cnt_d;
      end
   end

   assign txd         = txd_q;
   assign tx_busy     = tx_busy_q;
   assign tx_done     = tx_done_q;
   assign tx_overrun  = tx_overrun_q;
   assign baud_enable = baud_enable_q;
   assign baud_clr    = baud_clr_q;
   assign baud_select = baud_select_q;

endmodule

// File: tb/tb_uart_tx_controller.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_controller
// Directed bench for uart_tx_controller (DATA_BITS=8, STOP_BITS=1). A small
// baud controller model ticks every 16 clk while enabled; the cycle in which
// baud_clr is high counts as phase zero. Frame patterns below are written
// out by hand, bit 0 = start bit. Builds with or without UART_TX_PARITY_EN.
// ----------------------------------------------------------------------------
module tb_uart_tx_controller;

   localparam int BIT_CLKS = 16;

`ifdef UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
   localparam logic [10:0] FR_A5 = 11'b101_0100_1010;
   localparam logic [10:0] FR_07 = 11'b110_0000_1110;
   localparam logic [10:0] FR_3C = 11'b100_0111_1000;
   localparam logic [10:0] FR_80 = 11'b111_0000_0000;
`else
   localparam int FRAME_BITS = 10;
   localparam logic [9:0] FR_A5 = 10'b11_0100_1010;
   localparam logic [9:0] FR_07 = 10'b10_0000_1110;
   localparam logic [9:0] FR_3C = 10'b10_0111_1000;
   localparam logic [9:0] FR_80 = 10'b11_0000_0000;
`endif

   localparam int FRAME_CLKS = FRAME_BITS * BIT_CLKS;

   logic       clk = 1'b0;
   logic       reset;
   logic       tx_en;
   logic [2:0] cfg_baud_select;
   logic       tx_wr;
   logic [7:0] tx_data;
   logic       baud_tick;
   logic [2:0] baud_select;
   logic       baud_enable;
   logic       baud_clr;
   logic       txd;
   logic       tx_busy;
   logic       tx_done;
   logic       tx_overrun;

   int checks = 0;
   int passes = 0;

   logic [3:0] baud_cnt;

   uart_tx_controller #(
      .DATA_BITS (8),
      .STOP_BITS (1)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .tx_en           (tx_en),
      .cfg_baud_select (cfg_baud_select),
      .tx_wr           (tx_wr),
      .tx_data         (tx_data),
      .baud_tick       (baud_tick),
      .baud_select     (baud_select),
      .baud_enable     (baud_enable),
      .baud_clr        (baud_clr),
      .txd             (txd),
      .tx_busy         (tx_busy),
      .tx_done         (tx_done),
      .tx_overrun      (tx_overrun)
   );

   always #5 clk = ~clk;

   // Baud controller model: counter held at zero while disabled, the clear
   // cycle is count zero, a tick fires on count 15.
   always_ff @(posedge clk) begin
      if (reset || !baud_enable) baud_cnt <= 4'd0;
      else if (baud_clr)         baud_cnt <= 4'd1;
      else                       baud_cnt <= baud_cnt + 4'd1;
   end
   assign baud_tick = baud_enable && (baud_cnt == 4'd15);

   // Present a write for one cycle; returns in the first cycle after the
   // edge that sampled it.
   task automatic write_byte(input logic [7:0] d);
      @(negedge clk);
      tx_wr   = 1'b1;
      tx_data = d;
      @(negedge clk);
      tx_wr   = 1'b0;
   endtask

   // Walk one frame from its first cycle, checking every bit for its full
   // period, busy length, tx_done timing and baud_clr width. Optionally
   // injects an extra write or drops tx_en at a given cycle offset.
   task automatic run_frame(input logic [FRAME_BITS-1:0] expv, input string tag,
                            input int inject_at, input int en_drop_at,
                            output int ovr_at);
      int   bad [FRAME_BITS];
      logic badval [FRAME_BITS];
      int   busy_cnt;
      int   done_cnt;
      int   done_at;
      int   clr_cnt;
      busy_cnt = 0;
      done_cnt = 0;
      done_at  = -1;
      clr_cnt  = 0;
      ovr_at   = -1;
      for (int b = 0; b < FRAME_BITS; b++) begin
         bad[b]    = 0;
         badval[b] = 1'bx;
      end
      for (int k = 0; k < FRAME_CLKS + 3; k++) begin
         if (k < FRAME_CLKS) begin
            if (txd !== expv[k / BIT_CLKS]) begin
               bad[k / BIT_CLKS]++;
               badval[k / BIT_CLKS] = txd;
            end
            if (tx_busy === 1'b1) busy_cnt++;
         end
         if (baud_clr === 1'b1) clr_cnt++;
         if (tx_done === 1'b1) begin
            done_cnt++;
            done_at = k;
         end
         if (tx_overrun === 1'b1 && ovr_at < 0) ovr_at = k;
         if (k == inject_at) begin
            tx_wr   = 1'b1;
            tx_data = 8'hFF;
         end else begin
            tx_wr = 1'b0;
         end
         if (k == en_drop_at) tx_en = 1'b0;
         @(negedge clk);
      end
      tx_en = 1'b1;
      for (int b = 0; b < FRAME_BITS; b++) begin
         checks++;
         if (bad[b] != 0)
            $display("[TB] FAIL %s frame bit %0d: txd=%b in %0d of %0d clk, expected %b",
                     tag, b, badval[b], bad[b], BIT_CLKS, expv[b]);
         else passes++;
      end
      checks++;
      if (busy_cnt !== FRAME_CLKS)
         $display("[TB] FAIL %s busy length: got %0d clk, expected %0d", tag, busy_cnt, FRAME_CLKS);
      else passes++;
      checks++;
      if (done_cnt !== 1 || done_at !== FRAME_CLKS)
         $display("[TB] FAIL %s tx_done: %0d pulses last at cycle %0d, expected 1 at %0d",
                  tag, done_cnt, done_at, FRAME_CLKS);
      else passes++;
      checks++;
      if (clr_cnt !== 1)
         $display("[TB] FAIL %s baud_clr width: got %0d clk, expected 1", tag, clr_cnt);
      else passes++;
   endtask

   task automatic test_reset();
      reset           = 1'b1;
      tx_en           = 1'b1;
      tx_wr           = 1'b0;
      tx_data         = 8'h00;
      cfg_baud_select = 3'b101;
      repeat (3) @(negedge clk);
      checks++;
      if (txd !== 1'b1) $display("[TB] FAIL reset txd: got %b, expected 1", txd); else passes++;
      checks++;
      if (tx_busy !== 1'b0) $display("[TB] FAIL reset tx_busy: got %b, expected 0", tx_busy); else passes++;
      checks++;
      if (tx_done !== 1'b0) $display("[TB] FAIL reset tx_done: got %b, expected 0", tx_done); else passes++;
      checks++;
      if (tx_overrun !== 1'b0) $display("[TB] FAIL reset tx_overrun: got %b, expected 0", tx_overrun); else passes++;
      checks++;
      if (baud_enable !== 1'b0) $display("[TB] FAIL reset baud_enable: got %b, expected 0", baud_enable); else passes++;
      checks++;
      if (baud_clr !== 1'b0) $display("[TB] FAIL reset baud_clr: got %b, expected 0", baud_clr); else passes++;
      checks++;
      if (baud_select !== 3'b000) $display("[TB] FAIL reset baud_select: got %b, expected 000", baud_select); else passes++;
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (baud_select !== 3'b101) $display("[TB] FAIL idle baud_select follow: got %b, expected 101", baud_select); else passes++;
   endtask

   task automatic test_frame_a5();
      int ovr;
      write_byte(8'hA5);
      checks++;
      if (baud_enable !== 1'b1 || baud_clr !== 1'b1)
         $display("[TB] FAIL accept baud ctl: enable=%b clr=%b, expected 1 1", baud_enable, baud_clr);
      else passes++;
      run_frame(FR_A5, "a5", -1, -1, ovr);
      checks++;
      if (ovr !== -1) $display("[TB] FAIL a5 spurious overrun at cycle %0d, expected none", ovr); else passes++;
      checks++;
      if (baud_enable !== 1'b0) $display("[TB] FAIL a5 baud_enable after frame: got %b, expected 0", baud_enable); else passes++;
   endtask

   task automatic test_overrun();
      int ovr;
      int busy_seen;
      write_byte(8'h3C);
      run_frame(FR_3C, "overrun", 20, -1, ovr);
      checks++;
      if (ovr !== 21) $display("[TB] FAIL overrun timing: pulse at cycle %0d, expected 21", ovr); else passes++;
      busy_seen = 0;
      for (int k = 0; k < 40; k++) begin
         if (tx_busy !== 1'b0 || txd !== 1'b1) busy_seen++;
         @(negedge clk);
      end
      checks++;
      if (busy_seen !== 0) $display("[TB] FAIL overrun second frame: %0d active cycles, expected 0", busy_seen); else passes++;
   endtask

   task automatic test_back_to_back();
      int ovr;
      write_byte(8'h07);
      run_frame(FR_07, "done_cycle_wr", FRAME_CLKS, -1, ovr);
      checks++;
      if (ovr !== FRAME_CLKS + 1)
         $display("[TB] FAIL done-cycle write overrun: pulse at %0d, expected %0d", ovr, FRAME_CLKS + 1);
      else passes++;
      checks++;
      if (tx_busy !== 1'b0) $display("[TB] FAIL done-cycle write started frame: tx_busy=%b, expected 0", tx_busy); else passes++;
      write_byte(8'h80);
      run_frame(FR_80, "b2b_next", -1, -1, ovr);
   endtask

   task automatic test_baud_select();
      int k;
      int held_bad;
      cfg_baud_select = 3'b111;
      repeat (2) @(negedge clk);
      write_byte(8'h55);
      cfg_baud_select = 3'b011;
      k        = 0;
      held_bad = 0;
      while (tx_busy === 1'b1 && k < 400) begin
         if (baud_select !== 3'b111) held_bad++;
         @(negedge clk);
         k++;
      end
      checks++;
      if (k >= 400) $display("[TB] FAIL baud frame timeout: busy after %0d clk, expected idle by %0d", k, FRAME_CLKS); else passes++;
      checks++;
      if (held_bad !== 0) $display("[TB] FAIL baud_select frozen: %0d cycles not 111, expected 0", held_bad); else passes++;
      checks++;
      if (baud_select !== 3'b111) $display("[TB] FAIL baud_select in done cycle: got %b, expected 111", baud_select); else passes++;
      @(negedge clk);
      checks++;
      if (baud_select !== 3'b011) $display("[TB] FAIL baud_select after idle: got %b, expected 011", baud_select); else passes++;
   endtask

   task automatic test_tx_en();
      int ovr;
      int active;
      int ovr_cnt;
      tx_en = 1'b0;
      write_byte(8'h5A);
      checks++;
      if (tx_overrun !== 1'b1) $display("[TB] FAIL disabled write overrun: got %b, expected 1", tx_overrun); else passes++;
      active  = 0;
      ovr_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         if (tx_busy !== 1'b0 || txd !== 1'b1 || baud_enable !== 1'b0) active++;
         if (tx_overrun === 1'b1) ovr_cnt++;
         @(negedge clk);
      end
      checks++;
      if (active !== 0) $display("[TB] FAIL disabled write frame: %0d active cycles, expected 0", active); else passes++;
      checks++;
      if (ovr_cnt !== 1) $display("[TB] FAIL disabled write overrun width: %0d clk, expected 1", ovr_cnt); else passes++;
      tx_en = 1'b1;
      write_byte(8'h80);
      run_frame(FR_80, "en_drop", -1, 50, ovr);
      checks++;
      if (ovr !== -1) $display("[TB] FAIL en_drop spurious overrun at %0d, expected none", ovr); else passes++;
   endtask

   task automatic test_reset_midframe();
      int ovr;
      write_byte(8'hC3);
      repeat (70) @(negedge clk);
      checks++;
      if (txd !== 1'b0) $display("[TB] FAIL data bit 3 of C3: txd=%b, expected 0", txd); else passes++;
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (txd !== 1'b1 || tx_busy !== 1'b0 || baud_enable !== 1'b0)
         $display("[TB] FAIL mid-frame reset: txd=%b busy=%b enable=%b, expected 1 0 0",
                  txd, tx_busy, baud_enable);
      else passes++;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      write_byte(8'h3C);
      run_frame(FR_3C, "after_reset", -1, -1, ovr);
   endtask

   // Global bound so a stuck design can never hang the run.
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_frame_a5();
      test_overrun();
      test_back_to_back();
      test_baud_select();
      test_tx_en();
      test_reset_midframe();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_controller.md
Name: uart_tx_controller

Overview:
UART transmit sequencer that owns the baud tick generator: it latches the baud-rate configuration, enables and phase-aligns the generator, and shifts one frame onto txd per accepted write. The frame is start bit, DATA_BITS data bits LSB first, an optional parity bit and STOP_BITS stop bits. Sits between the host write interface and the baud controller and serial pin in the Lab2 UART.

Parameters:
DATA_BITS, 8, data bits per frame (5..8)
STOP_BITS, 1, stop bits per frame (1 or 2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
tx_en  input  1  transmitter enable; gates acceptance of new writes
cfg_baud_select  input  3  requested baud rate code
tx_wr  input  1  single-cycle write strobe
tx_data  input  DATA_BITS  byte to send; sampled when tx_wr is accepted
baud_tick  input  1  one-cycle bit-rate pulse from baud controller
baud_select  output  3  baud code driven to baud controller
baud_enable  output  1  enable to baud controller
baud_clr  output  1  one-cycle reset pulse to baud controller (phase align)
txd  output  1  serial line, idle high
tx_busy  output  1  frame in progress
tx_done  output  1  one-cycle pulse at end of the last stop bit
tx_overrun  output  1  one-cycle pulse when a write is dropped

Behaviour:
- Reset values: txd=1, tx_busy=0, tx_done=0, tx_overrun=0, baud_enable=0, baud_clr=0, baud_select=3'b000, state=IDLE. Reset mid-frame aborts; txd=1 at the next edge.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: baud_select <= cfg_baud_select every cycle. It is frozen in all other states.
- Accept: tx_wr=1, tx_en=1, state=IDLE. On that edge: latch tx_data into shift register; state<=START; txd<=0; tx_busy<=1; baud_enable<=1; baud_clr<=1 for exactly one cycle; bit counter<=0.
- baud_tick arriving in the same cycle as baud_clr is ignored.
- START: on baud_tick -> DATA, txd<=shift[0].
- DATA: on each baud_tick, shift right and increment the counter. After DATA_BITS ticks, go to PARITY (if enabled) or STOP, with txd<=parity bit or 1 respectively.
- PARITY: on baud_tick -> STOP, txd<=1.
- STOP: lasts STOP_BITS ticks. On the final tick: state<=IDLE, tx_busy<=0, baud_enable<=0, tx_done<=1 for one cycle.
- Every bit is held exactly one baud_tick period. The start bit begins on the cycle after acceptance.
- tx_wr while tx_busy=1, or with tx_en=0: the write is dropped and tx_overrun pulses the next cycle. Frame state is unaffected.
- tx_en deasserted mid-frame: the current frame completes normally.
- tx_wr in the same cycle as the final STOP tick: dropped (state is not yet IDLE), overrun pulses.
- No back-to-back acceptance within the tx_done cycle. The earliest re-accept is the cycle after tx_done.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: PARITY state is inserted; parity bit = XOR of latched data (even parity).
- Undefined: PARITY state and logic are absent; DATA goes directly to STOP.

Decomposition:
- Shared package uart_pkg: state encoding constants, baud code localparams (BAUD_300 ... BAUD_115200 = 3'b000 ... 3'b111), IDLE_LEVEL=1'b1.
- One natural sub-module: uart_tx_shifter (shift register, bit counter, parity accumulator), driven by load/shift strobes from the FSM.

Test Plan:
- Bench ticks every 16 clk, UART_TX_PARITY_EN off. Write 8'hA5 -> txd = 0,1,0,1,0,0,1,0,1,1, each bit held 16 clk. tx_done pulses once; tx_busy high for 160 clk.
- UART_TX_PARITY_EN on. Write 8'h07 -> parity bit = 1, frame is 11 bits. Write 8'hA5 -> parity bit = 0.
- Second tx_wr 20 clk into a frame -> tx_overrun pulse next cycle; the first frame's txd sequence is unchanged; no second frame.
- cfg_baud_select changed 3'b111 -> 3'b011 mid-frame -> baud_select holds 3'b111 until IDLE, then shows 3'b011 the next cycle.
- tx_en=0 with tx_wr -> no frame; txd stays 1; tx_overrun pulses. tx_en dropped mid-frame -> frame completes, tx_done pulses.
- reset asserted during DATA bit 3 -> next edge txd=1, tx_busy=0, baud_enable=0. A new write after reset release gives a clean frame.
